// File: rtl/rle_stream_scheduler.sv
// rtl/rle_stream_scheduler.sv - round-robin Y/U/V RLE record to UART byte-pair scheduler (optional stats: SCHED_STATS_EN)
module rle_stream_scheduler #(
  parameter int CountWidth  = 6,
  parameter int RowIdxWidth = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_row_start,
  input  logic                  i_frame_start,
  input  logic                  i_y_valid,
  input  logic [7:0]            i_y_val,
  input  logic [CountWidth-1:0] i_y_count,
  output logic                  o_y_ready,
  input  logic                  i_u_valid,
  input  logic [7:0]            i_u_val,
  input  logic [CountWidth-1:0] i_u_count,
  output logic                  o_u_ready,
  input  logic                  i_v_valid,
  input  logic [7:0]            i_v_val,
  input  logic [CountWidth-1:0] i_v_count,
  output logic                  o_v_ready,
  output logic [7:0]            o_byte,
  output logic                  o_byte_valid,
  input  logic                  i_tx_ready,
`ifdef SCHED_STATS_EN
  output logic [15:0]           o_stat_records,
  output logic [15:0]           o_stat_zero_drops,
`endif
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_VAL,
    S_SYNC_HDR,
    S_SYNC_IDX
  } state_t;

  // Channel ids double as the header tag in bits [7:6]
  localparam logic [1:0] CH_Y = 2'd0;
  localparam logic [1:0] CH_U = 2'd1;
  localparam logic [1:0] CH_V = 2'd2;

  state_t                 state_q;
  logic [1:0]             rr_q;
  logic [RowIdxWidth-1:0] row_q, row_d;
  logic                   sync_pending_q, sync_pending_d;
  logic                   armed_q;
  logic [7:0]             val_q;

  logic [2:0]             vld;
  logic                   gnt_found;
  logic [1:0]             gnt_ch;
  logic [2:0]             cand;
  logic [7:0]             gnt_val;
  logic [CountWidth-1:0]  gnt_cnt;
  logic [5:0]             hdr_cnt;
  logic                   take;
  logic                   zero_drop;
  logic                   xfer;

  assign vld  = {i_v_valid, i_u_valid, i_y_valid};
  assign xfer = o_byte_valid && i_tx_ready;

  // Pick the first valid channel after the last granted one (Y->U->V->Y)
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = CH_Y;
    cand      = 3'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (vld[cand[1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = cand[1:0];
      end
    end
  end

  // Select the granted record and zero-extend its count into the header field
  always_comb begin
    gnt_val = i_y_val;
    gnt_cnt = i_y_count;
    case (gnt_ch)
      CH_U:    begin gnt_val = i_u_val; gnt_cnt = i_u_count; end
      CH_V:    begin gnt_val = i_v_val; gnt_cnt = i_v_count; end
      default: begin gnt_val = i_y_val; gnt_cnt = i_y_count; end
    endcase
    hdr_cnt = '0;
    hdr_cnt[CountWidth-1:0] = gnt_cnt;
  end

  // Ready must be combinational so the encoder sees the grant in the same cycle;
  // armed_q holds it low until the first clock after reset release.
  assign take      = (state_q == S_IDLE) && armed_q && !sync_pending_q && gnt_found;
  assign zero_drop = take && (gnt_cnt == '0);
  assign o_y_ready = take && (gnt_ch == CH_Y);
  assign o_u_ready = take && (gnt_ch == CH_U);
  assign o_v_ready = take && (gnt_ch == CH_V);
  assign o_busy    = (state_q != S_IDLE);

  // Row-sync bookkeeping: a new row request wins over the clear, a frame start wins over the increment
  always_comb begin
    sync_pending_d = sync_pending_q;
    row_d          = row_q;
    if ((state_q == S_SYNC_IDX) && xfer) begin
      sync_pending_d = 1'b0;
      row_d          = row_q + 1'b1;
    end
    if (i_row_start)   sync_pending_d = 1'b1;
    if (i_frame_start) row_d = '0;
  end

  // Main FSM with registered byte outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      rr_q           <= CH_V;
      row_q          <= '0;
      sync_pending_q <= 1'b0;
      armed_q        <= 1'b0;
      val_q          <= 8'h00;
      o_byte         <= 8'h00;
      o_byte_valid   <= 1'b0;
    end else begin
      armed_q        <= 1'b1;
      row_q          <= row_d;
      sync_pending_q <= sync_pending_d;
      case (state_q)
        S_IDLE: begin
          if (armed_q && sync_pending_q) begin
            o_byte       <= 8'hC0;
            o_byte_valid <= 1'b1;
            state_q      <= S_SYNC_HDR;
          end else if (take) begin
            rr_q <= gnt_ch;
            if (!zero_drop) begin
              val_q        <= gnt_val;
              o_byte       <= {gnt_ch, hdr_cnt};
              o_byte_valid <= 1'b1;
              state_q      <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (xfer) begin
            o_byte  <= val_q;
            state_q <= S_VAL;
          end
        end
        S_VAL: begin
          if (xfer) begin
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        S_SYNC_HDR: begin
          // A frame start on this edge already applies to the index about to be sent
          if (xfer) begin
            o_byte  <= 8'(row_d);
            state_q <= S_SYNC_IDX;
          end
        end
        S_SYNC_IDX: begin
          if (xfer) begin
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          o_byte_valid <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic        rec_inc;
  logic [15:0] stat_rec_q, stat_zero_q;

  assign rec_inc = (state_q == S_VAL) && xfer;

  // Saturating record / zero-drop counters, cleared at each frame boundary
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stat_rec_q  <= 16'h0000;
      stat_zero_q <= 16'h0000;
    end else if (i_frame_start) begin
      stat_rec_q  <= 16'h0000;
      stat_zero_q <= 16'h0000;
    end else begin
      if (rec_inc && (stat_rec_q != 16'hFFFF))    stat_rec_q  <= stat_rec_q + 16'd1;
      if (zero_drop && (stat_zero_q != 16'hFFFF)) stat_zero_q <= stat_zero_q + 16'd1;
    end
  end

  assign o_stat_records    = stat_rec_q;
  assign o_stat_zero_drops = stat_zero_q;
`endif

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// tb/tb_rle_stream_scheduler.sv - self-checking bench for rle_stream_scheduler
module tb_rle_stream_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       i_row_start, i_frame_start;
  logic       i_y_valid, i_u_valid, i_v_valid;
  logic [7:0] i_y_val, i_u_val, i_v_val;
  logic [5:0] i_y_count, i_u_count, i_v_count;
  logic       o_y_ready, o_u_ready, o_v_ready;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       i_tx_ready;
  logic       o_busy;
`ifdef SCHED_STATS_EN
  logic [15:0] o_stat_records, o_stat_zero_drops;
`endif

  always #5 CLK = ~CLK;

  rle_stream_scheduler #(.CountWidth(6), .RowIdxWidth(8)) dut (
    .CLK(CLK), .RST(RST),
    .i_row_start(i_row_start), .i_frame_start(i_frame_start),
    .i_y_valid(i_y_valid), .i_y_val(i_y_val), .i_y_count(i_y_count), .o_y_ready(o_y_ready),
    .i_u_valid(i_u_valid), .i_u_val(i_u_val), .i_u_count(i_u_count), .o_u_ready(o_u_ready),
    .i_v_valid(i_v_valid), .i_v_val(i_v_val), .i_v_count(i_v_count), .o_v_ready(o_v_ready),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_tx_ready(i_tx_ready),
`ifdef SCHED_STATS_EN
    .o_stat_records(o_stat_records), .o_stat_zero_drops(o_stat_zero_drops),
`endif
    .o_busy(o_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [13:0] yq[$], uq[$], vq[$];
  logic [7:0]  obs[$], exp_b[$];
  int          gq[$], exp_g[$];
  int          tx_mode;
  logic        prev_stall;
  logic [7:0]  prev_byte;
  logic        s_bv, s_tx;
  logic [7:0]  s_byte;
  int          cyc, first_bv, first_gnt;
  int          exp_row;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic apply_src();
    i_y_valid = (yq.size() != 0);
    i_u_valid = (uq.size() != 0);
    i_v_valid = (vq.size() != 0);
    if (i_y_valid) {i_y_val, i_y_count} = yq[0];
    if (i_u_valid) {i_u_val, i_u_count} = uq[0];
    if (i_v_valid) {i_v_val, i_v_count} = vq[0];
  endtask

  // Queue a record at its source and append what the scheduler must emit for it
  task automatic push_rec(input int ch, input logic [7:0] v, input logic [5:0] c);
    case (ch)
      0:       yq.push_back({v, c});
      1:       uq.push_back({v, c});
      default: vq.push_back({v, c});
    endcase
    exp_g.push_back(ch);
    if (c != 0) begin
      exp_b.push_back(8'(ch * 64 + int'(c)));
      exp_b.push_back(v);
    end
    apply_src();
  endtask

  task automatic push_sync();
    exp_b.push_back(8'hC0);
    exp_b.push_back(8'(exp_row % 256));
    exp_row++;
  endtask

  // One clock: sample at negedge, apply source/tx updates just after posedge
  task automatic tick();
    logic ay, au, av;
    @(negedge CLK);
    cyc++;
    ay = o_y_ready; au = o_u_ready; av = o_v_ready;
    check("ready_without_valid",
          {29'b0, av & !i_v_valid, au & !i_u_valid, ay & !i_y_valid}, 32'd0);
    if (prev_stall) begin
      check("stall_valid", o_byte_valid, 1);
      check("stall_byte", o_byte, prev_byte);
    end
    prev_stall = o_byte_valid && !i_tx_ready;
    prev_byte  = o_byte;
    s_bv = o_byte_valid; s_byte = o_byte; s_tx = i_tx_ready;
    if (o_byte_valid && i_tx_ready) obs.push_back(o_byte);
    if (o_byte_valid && first_bv < 0) first_bv = cyc;
    if ((ay || au || av) && first_gnt < 0) first_gnt = cyc;
    if (ay) gq.push_back(0);
    if (au) gq.push_back(1);
    if (av) gq.push_back(2);
    @(posedge CLK);
    #1;
    if (ay) void'(yq.pop_front());
    if (au) void'(uq.pop_front());
    if (av) void'(vq.pop_front());
    apply_src();
    case (tx_mode)
      1:       i_tx_ready = !i_tx_ready;
      2:       i_tx_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic expect_stream(input string tag, input int limit);
    int n = 0;
    while (obs.size() < exp_b.size() && n < limit) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({tag, "_nbytes"}, obs.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < obs.size(); i++)
      check({tag, "_byte"}, obs[i], exp_b[i]);
    check({tag, "_ngrants"}, gq.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < gq.size(); i++)
      check({tag, "_grant"}, gq[i], exp_g[i]);
    obs.delete(); exp_b.delete(); gq.delete(); exp_g.delete();
  endtask

  task automatic pulse_row();
    i_row_start = 1'b1;
    tick();
    i_row_start = 1'b0;
  endtask

  initial begin
    RST = 1'b0; i_row_start = 0; i_frame_start = 0; i_tx_ready = 0;
    i_y_val = 0; i_u_val = 0; i_v_val = 0; i_y_count = 0; i_u_count = 0; i_v_count = 0;
    i_y_valid = 1; i_u_valid = 1; i_v_valid = 1;
    tx_mode = 0; prev_stall = 0; prev_byte = 0; cyc = 0; first_bv = -1; first_gnt = -1; exp_row = 0;
    #2;
    check("rst_byte", o_byte, 8'h00);
    check("rst_valid", o_byte_valid, 0);
    check("rst_ready", {o_v_ready, o_u_ready, o_y_ready}, 3'b000);
    check("rst_busy", o_busy, 0);
    apply_src();
    @(posedge CLK); #1;
    RST = 1'b1;
    i_tx_ready = 1'b1;

    // Round-robin with all three channels continuously valid
    for (int r = 0; r < 3; r++) begin
      push_rec(0, 8'(8'hA0 + r), 6'd1);
      push_rec(1, 8'(8'hB0 + r), 6'd2);
      push_rec(2, 8'(8'hD0 + r), 6'd3);
    end
    expect_stream("rr_123", 100);

    // Random records (including zero counts) under random tx backpressure
    tx_mode = 2;
    for (int r = 0; r < 20; r++)
      for (int ch = 0; ch < 3; ch++)
        push_rec(ch, 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63)));
    expect_stream("random", 3000);
    tx_mode = 0; i_tx_ready = 1'b1;

    // Y alone: one ready pulse, 05 then 3C, one cycle grant-to-valid latency
    first_bv = -1; first_gnt = -1;
    push_rec(0, 8'h3C, 6'd5);
    expect_stream("y_alone", 50);
    check("y_alone_latency", first_bv - first_gnt, 1);
    check("y_alone_idle_valid", o_byte_valid, 0);
    check("y_alone_idle_busy", o_busy, 0);

    // Row start during U header with toggling tx_ready
    tx_mode = 1;
    push_rec(1, 8'h5A, 6'd7);
    for (int n = 0; n < 30; n++) begin
      tick();
      if (s_bv && s_byte == 8'h47 && !s_tx) break;
    end
    pulse_row();
    push_sync();
    expect_stream("sync_first", 100);
    pulse_row();
    push_sync();
    expect_stream("sync_second", 100);
    tx_mode = 0; i_tx_ready = 1'b1;

    // Frame start, then a zero-count V record
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    exp_row = 0;
    push_rec(2, 8'h77, 6'd0);
    expect_stream("zero_count", 20);
`ifdef SCHED_STATS_EN
    check("stat_zero_drops", o_stat_zero_drops, 16'd1);
    check("stat_records", o_stat_records, 16'd0);
`endif

    // Row index wrap after 256 sync pairs
    for (int i = 0; i < 256; i++) begin
      pulse_row();
      push_sync();
      expect_stream("wrap_loop", 50);
    end
    pulse_row();
    push_sync();
    expect_stream("wrap_256", 50);

    // Frame start coincident with the index-byte transfer
    i_tx_ready = 1'b0;
    pulse_row();
    tick(); tick();
    i_tx_ready = 1'b1; tick();
    i_tx_ready = 1'b0; tick();
    i_tx_ready = 1'b1; i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
    push_sync();
    exp_row = 0;
    expect_stream("frame_at_idx", 20);
    pulse_row();
    push_sync();
    expect_stream("after_frame", 50);

    // Reset asserted while a VAL byte is stalled
    i_tx_ready = 1'b0;
    push_rec(0, 8'h11, 6'd9);
    tick(); tick(); tick();
    i_tx_ready = 1'b1; tick();
    i_tx_ready = 1'b0; tick();
    #2;
    RST = 1'b0;
    #1;
    check("midrst_byte", o_byte, 8'h00);
    check("midrst_valid", o_byte_valid, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", {o_v_ready, o_u_ready, o_y_ready}, 3'b000);
    obs.delete(); exp_b.delete(); gq.delete(); exp_g.delete();
    yq.delete(); uq.delete(); vq.delete();
    prev_stall = 0; exp_row = 0;
    push_rec(0, 8'h21, 6'd1);
    push_rec(1, 8'h22, 6'd2);
    push_rec(2, 8'h23, 6'd3);
    @(posedge CLK); #1;
    RST = 1'b1;
    i_tx_ready = 1'b1;
    expect_stream("post_reset", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
